// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory
// responder (slave), including the pipeline stall returned to the datapath.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store at a time,
// holds it for WAIT_CYCLES wait states, then completes it in a single
// response cycle. Misaligned or out-of-range accesses complete with resp_err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int          ADDR_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic              addr_err;

  // Decode of the captured address: word index and error condition.
  always_comb begin
    idx      = addr_q[ADDR_W+1:2];
    addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_W + 2)) != '0);
  end

  // State, wait counter and captured request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Next-state logic: accept in IDLE, count wait states, one response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs; read data and error are forced to zero outside the response cycle.
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.resp_valid = (state_q == S_RESP);
    bus.resp_err   = bus.resp_valid && addr_err;
    bus.resp_rdata = (bus.resp_valid && !addr_err) ? mem_q[idx] : '0;
    bus.stall      = bus.req_valid && !bus.resp_valid;
  end

  // Byte-lane store at the end of the response cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && we_q && !addr_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int W0 = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if b0();
  dmem_responder_if b1();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access on the WAIT_CYCLES=2 instance, checked against ref_mem.
  task automatic acc0(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input bit drop);
    logic [31:0] exp_rd;
    logic        exp_err;
    int unsigned lat;
    bit          got;
    exp_err = (addr[1:0] != 2'b00) || (addr >= 32'd1024);
    exp_rd  = exp_err ? 32'h0 : ref_mem[addr[9:2]];
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_we = we; b0.req_addr = addr;
    b0.req_wdata = wd;   b0.req_be = be;
    #1;
    chk("ready_accept", 32'(b0.req_ready), 32'd1);
    chk("stall_accept", 32'(b0.stall), 32'd1);
    @(posedge clk);
    lat = 0; got = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (drop && k == 1) begin b0.req_valid = 1'b0; #1; end
      if (b0.resp_valid) begin
        got = 1; lat = k;
      end else begin
        chk("ready_wait", 32'(b0.req_ready), 32'd0);
        chk("stall_wait", 32'(b0.stall), drop ? 32'd0 : 32'd1);
        chk("rdata_wait", b0.resp_rdata, 32'h0);
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("latency", lat, W0 + 1);
    if (got) begin
      chk("resp_err", 32'(b0.resp_err), 32'(exp_err));
      if (!we) chk("resp_rdata", b0.resp_rdata, exp_rd);
      chk("ready_resp", 32'(b0.req_ready), 32'd0);
      chk("stall_resp", 32'(b0.stall), 32'd0);
    end
    b0.req_valid = 1'b0;
    if (we && !exp_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[addr[9:2]][8*i +: 8] = wd[8*i +: 8];
    @(negedge clk);
    chk("valid_after", 32'(b0.resp_valid), 32'd0);
    chk("rdata_after", b0.resp_rdata, 32'h0);
    chk("err_after", 32'(b0.resp_err), 32'd0);
    chk("ready_after", 32'(b0.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a, d, d0, d1;
    logic [3:0]  be;
    logic        we;
    int unsigned r;
    bit          seen;

    b0.req_valid = 0; b0.req_we = 0; b0.req_addr = '0; b0.req_wdata = '0; b0.req_be = '0;
    b1.req_valid = 0; b1.req_we = 0; b1.req_addr = '0; b1.req_wdata = '0; b1.req_be = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0", 32'(b0.req_ready), 32'd1);
    chk("rst_valid0", 32'(b0.resp_valid), 32'd0);
    chk("rst_rdata0", b0.resp_rdata, 32'h0);
    chk("rst_err0", 32'(b0.resp_err), 32'd0);
    chk("rst_ready1", 32'(b1.req_ready), 32'd1);
    chk("rst_valid1", 32'(b1.resp_valid), 32'd0);
    reset = 1'b0;

    // Fill every word with random data so the model fully knows the memory.
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      acc0(1'b1, 32'(i * 4), d, 4'hF, 0);
    end

    // Directed cases from the block's expected behaviour.
    acc0(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    acc0(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("deadbeef_model", ref_mem[4], 32'hDEADBEEF);
    acc0(1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
    acc0(1'b0, 32'h10, 32'h0, 4'hF, 0);
    acc0(1'b1, 32'h10, 32'h11220000, 4'hC, 0);
    acc0(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("byte_lane_model", ref_mem[4], 32'h1122BEAA);
    acc0(1'b0, 32'h13, 32'h0, 4'hF, 0);
    acc0(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0);
    acc0(1'b0, 32'h0, 32'h0, 4'hF, 0);
    acc0(1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, 0);
    acc0(1'b0, 32'h30, 32'h0, 4'hF, 0);
    acc0(1'b1, 32'h34, 32'h5A5A5A5A, 4'hF, 1);
    acc0(1'b0, 32'h34, 32'h0, 4'hF, 1);

    // Reset during the second wait cycle discards the pending store.
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_addr = 32'h20;
    b0.req_wdata = 32'h12345678; b0.req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(b0.req_ready), 32'd1);
    chk("rst_mid_valid", 32'(b0.resp_valid), 32'd0);
    b0.req_valid = 1'b0;
    @(negedge clk);
    chk("rst_hold_valid", 32'(b0.resp_valid), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (b0.resp_valid) seen = 1;
    end
    chk("rst_no_pulse", 32'(seen), 32'd0);
    acc0(1'b0, 32'h20, 32'h0, 4'hF, 0);

    // Randomized mix: mostly legal accesses plus misaligned and out-of-range.
    for (int n = 0; n < 60; n++) begin
      r  = $urandom_range(0, 9);
      a  = {22'h0, 8'($urandom), 2'b00};
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 1) a = a | (32'h1 << $urandom_range(10, 31));
      we = 1'($urandom);
      be = 4'($urandom);
      d  = $urandom;
      acc0(we, a, d, be, 0);
    end

    // Zero-wait instance: seed two words, then two back-to-back held loads.
    d0 = $urandom; d1 = $urandom;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 32'(i * 4);
      b1.req_wdata = (i == 0) ? d0 : d1; b1.req_be = 4'hF;
      @(negedge clk);
      chk("w0_store_valid", 32'(b1.resp_valid), 32'd1);
      chk("w0_store_err", 32'(b1.resp_err), 32'd0);
      b1.req_valid = 1'b0;
    end
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 32'h0;
    #1;
    chk("w0_ready_T", 32'(b1.req_ready), 32'd1);
    chk("w0_valid_T", 32'(b1.resp_valid), 32'd0);
    chk("w0_stall_T", 32'(b1.stall), 32'd1);
    @(negedge clk);
    chk("w0_ready_T1", 32'(b1.req_ready), 32'd0);
    chk("w0_valid_T1", 32'(b1.resp_valid), 32'd1);
    chk("w0_rdata_T1", b1.resp_rdata, d0);
    chk("w0_stall_T1", 32'(b1.stall), 32'd0);
    b1.req_addr = 32'h4;
    @(negedge clk);
    chk("w0_ready_T2", 32'(b1.req_ready), 32'd1);
    chk("w0_valid_T2", 32'(b1.resp_valid), 32'd0);
    chk("w0_stall_T2", 32'(b1.stall), 32'd1);
    @(negedge clk);
    chk("w0_ready_T3", 32'(b1.req_ready), 32'd0);
    chk("w0_valid_T3", 32'(b1.resp_valid), 32'd1);
    chk("w0_rdata_T3", b1.resp_rdata, d1);
    b1.req_valid = 1'b0;
    @(negedge clk);
    chk("w0_valid_after", 32'(b1.resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
